// File: rtl/mfp_ahb_botio_pkg.sv
// Shared constants for the bot I/O AHB slave: register word indices,
// BotInfo field offsets and the address-match level used by the top level.
package mfp_ahb_botio_pkg;

  localparam logic [2:0] REG_INFO = 3'd0;
  localparam logic [2:0] REG_CTRL = 3'd1;
  localparam logic [2:0] REG_UPD  = 3'd2;
  localparam logic [2:0] REG_ACK  = 3'd3;

  // BotInfo = {LocX, LocY, Sensors, Info}, one byte each
  localparam int INFO_LOCX_LSB = 24;
  localparam int INFO_LOCY_LSB = 16;
  localparam int INFO_SENS_LSB = 8;
  localparam int INFO_INFO_LSB = 0;

  localparam logic [1:0] HTRANS_IDLE  = 2'b00;
  localparam logic       IO_BOT_MATCH = 1'b1;

  function automatic logic bus_valid(input logic hsel, input logic [1:0] htrans);
    return (hsel == IO_BOT_MATCH) && (htrans != HTRANS_IDLE);
  endfunction

endpackage

// File: rtl/mfp_botio_updsync.sv
// BotUpd rising-edge detect and update-flag keeping; set beats clear.
// Optional registered interrupt when MFP_BOTIO_IRQ_EN is defined.
module mfp_botio_updsync (
  input  logic clk,
  input  logic rst,
  input  logic bot_upd,
  input  logic ack_clr,
  output logic snap_load,
  output logic flag
`ifdef MFP_BOTIO_IRQ_EN
  , output logic irq
`endif
);

  logic upd_q;

  assign snap_load = bot_upd & ~upd_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      upd_q <= 1'b0;
      flag  <= 1'b0;
    end else begin
      upd_q <= bot_upd;
      if (snap_load)
        flag <= 1'b1;
      else if (ack_clr)
        flag <= 1'b0;
    end
  end

`ifdef MFP_BOTIO_IRQ_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      irq <= 1'b0;
    else
      irq <= flag;
  end
`endif

endmodule

// File: rtl/mfp_ahb_botio.sv
// AHB-lite slave exposing bot status snapshot, motor control and update flag.
// Define MFP_BOTIO_IRQ_EN to add the BotIrq output.
module mfp_ahb_botio
  import mfp_ahb_botio_pkg::*;
#(
  parameter logic [7:0] CTRL_RST = 8'h00,
  parameter logic [2:0] UPD_ADDR = REG_UPD
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic [2:0]  HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [31:0] HWDATA,
  input  logic        HSEL,
  output logic [31:0] HRDATA,
  input  logic [31:0] BotInfo,
  input  logic        BotUpd,
  output logic [7:0]  BotCtrl
`ifdef MFP_BOTIO_IRQ_EN
  , output logic      BotIrq
`endif
);

  logic        addr_valid;
  logic        a_valid;
  logic        a_write;
  logic [2:0]  a_addr;
  logic        wr_en;
  logic        ctrl_wr;
  logic        ack_clr;
  logic [7:0]  bot_ctrl;
  logic [7:0]  ctrl_next;
  logic [31:0] snapshot;
  logic [31:0] rd_data;
  logic        snap_load;
  logic        flag;
  logic        unused_hwdata;

  assign unused_hwdata = ^HWDATA[31:8];

  assign addr_valid = bus_valid(HSEL, HTRANS);
  assign wr_en      = a_valid & a_write;
  assign ctrl_wr    = wr_en && (a_addr == REG_CTRL);
  assign ack_clr    = wr_en && (a_addr == REG_ACK) && HWDATA[0];
  // Forward a CTRL write in its data phase so an overlapping read sees it
  assign ctrl_next  = ctrl_wr ? HWDATA[7:0] : bot_ctrl;

  always_comb begin
    rd_data = 32'h0;
    if (HADDR == REG_INFO)
      rd_data = snapshot;
    else if (HADDR == REG_CTRL)
      rd_data = {24'h0, ctrl_next};
    else if (HADDR == UPD_ADDR)
      rd_data = {31'h0, flag};
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      a_valid  <= 1'b0;
      a_write  <= 1'b0;
      a_addr   <= 3'd0;
      bot_ctrl <= CTRL_RST;
      snapshot <= 32'h0;
      HRDATA   <= 32'h0;
    end else begin
      a_valid  <= addr_valid;
      a_write  <= HWRITE;
      a_addr   <= HADDR;
      bot_ctrl <= ctrl_next;
      HRDATA   <= (addr_valid && !HWRITE) ? rd_data : 32'h0;
      if (snap_load)
        snapshot <= {BotInfo[INFO_LOCX_LSB +: 8], BotInfo[INFO_LOCY_LSB +: 8],
                     BotInfo[INFO_SENS_LSB +: 8], BotInfo[INFO_INFO_LSB +: 8]};
    end
  end

  assign BotCtrl = bot_ctrl;

  mfp_botio_updsync u_updsync (
    .clk       (HCLK),
    .rst       (HRESET),
    .bot_upd   (BotUpd),
    .ack_clr   (ack_clr),
    .snap_load (snap_load),
    .flag      (flag)
`ifdef MFP_BOTIO_IRQ_EN
    , .irq     (BotIrq)
`endif
  );

endmodule

// File: doc/mfp_ahb_botio.md
MFP_AHB_BOTIO -- requirements
Module: mfp_ahb_botio

Interface
REQ-001 Parameter CTRL_RST, default 8'h00, BotCtrl value after reset.
REQ-002 Parameter UPD_ADDR, default 3'd2, word index of the update-flag register.
REQ-003 HCLK  in  1  single clock; all logic on its rising edge.
REQ-004 HRESET  in  1  asynchronous, active-high reset.
REQ-005 HADDR  in  3  word address bits [4:2] of the AHB address-phase address.
REQ-006 HTRANS  in  2  AHB transfer type; 2'b00 = IDLE.
REQ-007 HWRITE  in  1  address-phase write strobe.
REQ-008 HWDATA  in  32  data-phase write data.
REQ-009 HSEL  in  1  slave select from the bus decoder.
REQ-010 HRDATA  out  32  registered read data.
REQ-011 BotInfo  in  32  live bot status {LocX[31:24], LocY[23:16], Sensors[15:8], Info[7:0]}.
REQ-012 BotUpd  in  1  bot "registers updated" level from the bot core, same clock domain.
REQ-013 BotCtrl  out  8  motor control to the bot core.
REQ-014 BotIrq  out  1  update interrupt; present only with MFP_BOTIO_IRQ_EN.

Function
REQ-015 Valid access SHALL be HSEL=1 and HTRANS!=IDLE in the address phase; the block SHALL register HADDR, HWRITE and valid.
REQ-016 Writes SHALL take effect at the end of the data phase: the cycle after the address phase, using HWDATA.
REQ-017 Reads SHALL drive HRDATA registered, valid in the data phase, one cycle after the address phase; no wait states.
REQ-018 Register map by word index: 0 INFO (RO snapshot), 1 CTRL (RW, bits[7:0]), UPD_ADDR UPD (RO, bit0 = flag), 3 ACK (WO).
REQ-019 All other indices SHALL read 32'h0, and writes to them SHALL be ignored; writes to RO registers SHALL be ignored.
REQ-020 Unused upper read bits SHALL read 0.
REQ-021 A BotUpd 0->1 edge (registered edge detect) SHALL, on the next edge, set the flag and load snapshot <= BotInfo.
REQ-022 The snapshot SHALL hold its value until the next BotUpd rising edge; a level held high SHALL NOT retrigger.
REQ-023 A write to ACK with HWDATA[0]=1 SHALL clear the flag; HWDATA[0]=0 SHALL have no effect.
REQ-024 When a set and a clear occur in the same cycle, set SHALL win.
REQ-025 A read of INFO issued in the same cycle as a snapshot load SHALL return the pre-load value.
REQ-026 Back-to-back transfers SHALL be supported: an address phase overlapping a previous data phase SHALL be captured normally.
REQ-027 A write to CTRL followed immediately by a read of CTRL SHALL return the new value.

Reset
REQ-028 On HRESET: BotCtrl=CTRL_RST, flag=0, snapshot=0, HRDATA=0, edge-detect register=0, registered address-phase valid=0, BotIrq=0.
REQ-029 Reset asserted mid-transfer SHALL abort it; no write SHALL land after reset deasserts.

Configuration
REQ-030 With MFP_BOTIO_IRQ_EN defined: BotIrq SHALL be registered and equal to the flag (asserts 1 cycle after set, deasserts 1 cycle after ACK).
REQ-031 Without MFP_BOTIO_IRQ_EN: no BotIrq port and no IRQ logic; the register map is unchanged.

Structure
REQ-032 Shared header SHALL hold the register indices (INFO/CTRL/UPD/ACK) and the BotInfo field offsets; the top level SHALL take the IO_BOT address-match constant from the same place.
REQ-033 One sub-module, mfp_botio_updsync (edge detect, flag set/clear priority, IRQ); all other logic inline.

Verification
REQ-034 Reset, then read CTRL and UPD -> 32'h0 and 32'h0; BotCtrl=8'h00.
REQ-035 Write CTRL=32'hFFFF_FFA5, then read CTRL -> BotCtrl=8'hA5 one cycle after the data phase; read returns 32'h0000_00A5.
REQ-036 BotInfo=32'h1234_5601, pulse BotUpd -> UPD reads 1 and INFO reads 32'h1234_5601. Change BotInfo to 32'hDEAD_BEEF with no edge -> INFO still reads 32'h1234_5601.
REQ-037 ACK write with HWDATA=1 in the same cycle as a BotUpd rising edge -> UPD reads 1 afterwards. A later ACK with 1 -> UPD reads 0; ACK with 0 -> no change.
REQ-038 Read of index 5 -> 32'h0. Write to INFO -> snapshot unchanged. Back-to-back write CTRL / read CTRL -> new value returned.
REQ-039 With MFP_BOTIO_IRQ_EN: BotUpd edge -> BotIrq high 2 cycles later. Assert HRESET mid-write to CTRL -> BotCtrl=8'h00 and BotIrq=0.
